// File: rtl/mean_pkg.sv
// Shared mode encodings and sizing helpers for the mean_window_stream block.
package mean_pkg;

    localparam int MODE_BLOCK    = 0;
    localparam int MODE_SLIDING  = 1;
    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Accumulator width: N samples of DATA_W bits can never exceed DATA_W+LOG2_N bits.
    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/sample_window.sv
// N-entry circular sample buffer: one write port, combinational read of the
// entry at the write pointer, which is the oldest sample once the window is full.
module sample_window #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LOG2_N-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int N = 1 << LOG2_N;

    logic [DATA_W-1:0] mem_q [N];

    // Store the accepted sample; contents are never cleared, fill gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[wr_ptr];

endmodule

// File: rtl/mean_window_stream.sv
// Streaming mean over a window of N = 2^LOG2_N unsigned samples, either as
// non-overlapping blocks or as a moving window, with one-cycle result latency.
module mean_window_stream
    import mean_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LOG2_N  = 3,
    parameter int SLIDING = MODE_BLOCK,
    parameter int ROUND   = ROUND_TRUNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LOG2_N:0]   fill
);

    localparam int N  = 1 << LOG2_N;
    localparam int AW = acc_w(DATA_W, LOG2_N);

    localparam logic [AW-1:0]   HALF      = AW'(N / 2);
    localparam logic [LOG2_N:0] FILL_FULL = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);

    if (LOG2_N < 1 || LOG2_N > 6) begin : g_bad_log2_n
        $error("mean_window_stream: LOG2_N must be in 1..6");
    end
    if (SLIDING != MODE_BLOCK && SLIDING != MODE_SLIDING) begin : g_bad_sliding
        $error("mean_window_stream: SLIDING must be 0 or 1");
    end
    if (ROUND != ROUND_TRUNC && ROUND != ROUND_HALF_UP) begin : g_bad_round
        $error("mean_window_stream: ROUND must be 0 or 1");
    end

    logic [AW-1:0]     sum_q, sum_d, sum_next;
    logic [LOG2_N:0]   fill_q, fill_d;
    logic [LOG2_N-1:0] wptr_q, wptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] oldest;

    // Rounded sum cannot exceed AW bits: max sum is 2^AW - N, plus N/2.
    function automatic logic [DATA_W-1:0] mean_of(input logic [AW-1:0] s);
        logic [AW-1:0] r;
        r = (ROUND == ROUND_HALF_UP) ? s + HALF : s;
        return DATA_W'(r >> LOG2_N);
    endfunction

    if (SLIDING == MODE_SLIDING) begin : g_window
        logic win_we;
        assign win_we = in_valid && !clear && !rst;
        sample_window #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N)
        ) u_window (
            .clk     (clk),
            .wr_en   (win_we),
            .wr_ptr  (wptr_q),
            .wr_data (in_data),
            .rd_data (oldest)
        );
    end else begin : g_no_window
        assign oldest = '0;
    end

    // Next-state: clear flushes, otherwise an accepted sample updates sum/fill
    // and raises a result pulse when a window completes.
    always_comb begin
        sum_d       = sum_q;
        fill_d      = fill_q;
        wptr_d      = wptr_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sum_next    = '0;
        if (clear) begin
            sum_d  = '0;
            fill_d = '0;
            wptr_d = '0;
        end else if (in_valid) begin
            if (SLIDING == MODE_SLIDING) begin
                // Oldest sample is still inside sum_q, so the modular subtract is exact.
                wptr_d = wptr_q + 1'b1;
                if (fill_q == FILL_FULL) begin
                    sum_next = sum_q + AW'(in_data) - AW'(oldest);
                end else begin
                    sum_next = sum_q + AW'(in_data);
                    fill_d   = fill_q + 1'b1;
                end
                sum_d = sum_next;
                if (fill_q >= FILL_LAST) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mean_of(sum_next);
                end
            end else begin
                sum_next = sum_q + AW'(in_data);
                if (fill_q == FILL_LAST) begin
                    sum_d       = '0;
                    fill_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = mean_of(sum_next);
                end else begin
                    sum_d  = sum_next;
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset overriding clear and in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            fill_q      <= '0;
            wptr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            wptr_q      <= wptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fill      = fill_q;

endmodule
